// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the in-order back end: tracks in-flight
// destinations in a shadow pipeline and produces forward selects, stall, flush and bubble.
module hazard_fwd_unit #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ALU_RDY  = 2,
  parameter int unsigned LOAD_RDY = 3,
  parameter int unsigned SELW     = $clog2(DEPTH + 1),
  parameter int unsigned CNTW     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [4:0]      id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            redirect,
  input  logic            freeze,
  output logic            stall_id,
  output logic            flush_id,
  output logic            ex_bubble,
  output logic [SELW-1:0] ex_fwd_sel_rs1,
  output logic [SELW-1:0] ex_fwd_sel_rs2,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  // The write-back entry is never a forwarding source (write-through file), so only
  // stages 1..DEPTH-1 are kept.
  localparam int unsigned NSRC = DEPTH - 1;

  logic [NSRC:1]      e_v;
  logic [NSRC:1]      e_we;
  logic [NSRC:1]      e_ld;
  logic [NSRC:1][4:0] e_rd;

  logic            haz_rs1;
  logic            haz_rs2;
  logic            hazard;
  logic [SELW-1:0] sel_rs1;
  logic [SELW-1:0] sel_rs2;

  // Youngest matching producer decides: forward from stage k+1 if ready then, else hazard.
  function automatic logic [SELW:0] resolve(
    input logic [4:0]         rs,
    input logic               used,
    input logic               valid,
    input logic [NSRC:1]      v,
    input logic [NSRC:1]      we,
    input logic [NSRC:1]      ld,
    input logic [NSRC:1][4:0] rd
  );
    logic            hit;
    logic            haz;
    logic [SELW-1:0] sel;
    int unsigned     rdy;
    hit = 1'b0;
    haz = 1'b0;
    sel = '0;
    rdy = ALU_RDY;
    if (valid && used && rs != 5'd0) begin
      for (int unsigned k = 1; k <= NSRC; k++) begin
        if (!hit && v[k] && we[k] && rd[k] == rs) begin
          hit = 1'b1;
          rdy = ld[k] ? LOAD_RDY : ALU_RDY;
          if (k + 1 >= rdy) sel = SELW'(k + 1);
          else              haz = 1'b1;
        end
      end
    end
    return {haz, sel};
  endfunction

  always_comb begin
    {haz_rs1, sel_rs1} = resolve(id_rs1, id_rs1_used, id_valid, e_v, e_we, e_ld, e_rd);
    {haz_rs2, sel_rs2} = resolve(id_rs2, id_rs2_used, id_valid, e_v, e_we, e_ld, e_rd);
    hazard    = haz_rs1 | haz_rs2;
    // Redirect outranks hazard: the decode instruction is discarded, not held.
    stall_id  = hazard & ~redirect & ~freeze;
    flush_id  = redirect & ~freeze;
    ex_bubble = (hazard | redirect | ~id_valid) & ~freeze;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_v            <= '0;
      e_we           <= '0;
      e_ld           <= '0;
      e_rd           <= '0;
      ex_fwd_sel_rs1 <= '0;
      ex_fwd_sel_rs2 <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      if (!freeze) begin
        for (int unsigned k = 2; k <= NSRC; k++) begin
          e_v[k]  <= e_v[k-1];
          e_we[k] <= e_we[k-1];
          e_ld[k] <= e_ld[k-1];
          e_rd[k] <= e_rd[k-1];
        end
        e_v[1]         <= ~ex_bubble;
        e_we[1]        <= id_we & ~ex_bubble;
        e_ld[1]        <= id_is_load & ~ex_bubble;
        e_rd[1]        <= id_rd;
        ex_fwd_sel_rs1 <= ex_bubble ? '0 : sel_rs1;
        ex_fwd_sel_rs2 <= ex_bubble ? '0 : sel_rs2;
      end
      // stall_id/flush_id are already gated by freeze.
      if (stall_id && stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
      if (flush_id && flush_cnt != '1) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: default instance plus a DEPTH=5/LOAD_RDY=4 instance with
// 2-bit counters, driven from vector tables with a scoreboard for the registered outputs.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, redirect, freeze;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        a_stall, a_flush, a_bub;
  logic [1:0]  a_sel1, a_sel2;
  logic [31:0] a_scnt, a_fcnt;
  logic        b_stall, b_flush, b_bub;
  logic [2:0]  b_sel1, b_sel2;
  logic [1:0]  b_scnt, b_fcnt;

  hazard_fwd_unit dut_a (
    .clk(clk), .rst(rst_a), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .redirect(redirect), .freeze(freeze),
    .stall_id(a_stall), .flush_id(a_flush), .ex_bubble(a_bub),
    .ex_fwd_sel_rs1(a_sel1), .ex_fwd_sel_rs2(a_sel2), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_fwd_unit #(.DEPTH(5), .ALU_RDY(2), .LOAD_RDY(4), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst_b), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .redirect(redirect), .freeze(freeze),
    .stall_id(b_stall), .flush_id(b_flush), .ex_bubble(b_bub),
    .ex_fwd_sel_rs1(b_sel1), .ex_fwd_sel_rs2(b_sel2), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, ld, redir, frz;
    logic       stall, flush, bub;
    int         sel1, sel2, scnt, fcnt;
  } vec_t;

  typedef struct {
    int sel1, sel2, scnt, fcnt;
  } exp_t;

  vec_t va[$];
  vec_t vb[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
    input int rd, input logic we, input logic ld, input logic redir, input logic frz,
    input logic stall, input logic flush, input logic bub,
    input int sel1, input int sel2, input int scnt, input int fcnt);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = u1; t.u2 = u2; t.rd = 5'(rd);
    t.we = we; t.ld = ld; t.redir = redir; t.frz = frz;
    t.stall = stall; t.flush = flush; t.bub = bub;
    t.sel1 = sel1; t.sel2 = sel2; t.scnt = scnt; t.fcnt = fcnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One decode cycle: check combinational outputs mid-cycle, registered ones after the edge.
  task automatic run_vec(input vec_t t, input bit use_b, input string tag);
    exp_t e;
    @(negedge clk);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rs1_used = t.u1; id_rs2_used = t.u2;
    id_rd = t.rd; id_we = t.we; id_is_load = t.ld; redirect = t.redir; freeze = t.frz;
    #1;
    chk({tag, " stall_id"},  int'(use_b ? b_stall : a_stall), int'(t.stall));
    chk({tag, " flush_id"},  int'(use_b ? b_flush : a_flush), int'(t.flush));
    chk({tag, " ex_bubble"}, int'(use_b ? b_bub : a_bub),     int'(t.bub));
    e.sel1 = t.sel1; e.sel2 = t.sel2; e.scnt = t.scnt; e.fcnt = t.fcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " sel_rs1"},   use_b ? int'(b_sel1) : int'(a_sel1), e.sel1);
    chk({tag, " sel_rs2"},   use_b ? int'(b_sel2) : int'(a_sel2), e.sel2);
    chk({tag, " stall_cnt"}, use_b ? int'(b_scnt) : int'(a_scnt), e.scnt);
    chk({tag, " flush_cnt"}, use_b ? int'(b_fcnt) : int'(a_fcnt), e.fcnt);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_we = 0; id_is_load = 0; redirect = 0; freeze = 0;
  endtask

  initial begin
    //       v rs1 rs2 u1 u2 rd we ld rdr frz  stl fl bub  s1 s2 sc fc
    va.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0)); // add x5
    va.push_back(mk(1,  5,  3, 1, 1,  6, 1, 0, 0, 0,  0, 0, 0,  2, 0, 0, 0)); // sub x6,x5
    va.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0)); // lw x7
    va.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  1, 0, 1,  0, 0, 1, 0)); // add x8 stall
    va.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  0, 0, 0,  3, 3, 1, 0)); // add x8 go
    va.push_back(mk(1,  1,  2, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // x9 older
    va.push_back(mk(1,  3,  4, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // x9 younger
    va.push_back(mk(1,  9,  9, 1, 0, 10, 1, 0, 0, 0,  0, 0, 0,  2, 0, 1, 0)); // youngest wins
    va.push_back(mk(1,  1,  0, 1, 0,  0, 1, 1, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // lw x0
    va.push_back(mk(1,  0,  0, 1, 1, 11, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // reads x0
    va.push_back(mk(1,  1,  0, 1, 0, 12, 1, 1, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // lw x12
    va.push_back(mk(1,  2, 12, 1, 0, 13, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // rs2 unused
    va.push_back(mk(1,  1,  0, 1, 0, 14, 1, 1, 0, 0,  0, 0, 0,  0, 0, 1, 0)); // lw x14
    va.push_back(mk(1, 14,  2, 1, 1, 15, 1, 0, 1, 0,  0, 1, 1,  0, 0, 1, 1)); // hazard+redirect
    va.push_back(mk(0, 14,  0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 1, 1)); // invalid slot
    va.push_back(mk(1,  1,  2, 1, 1, 20, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1)); // add x20
    va.push_back(mk(1, 20,  0, 1, 0, 16, 1, 1, 0, 0,  0, 0, 0,  2, 0, 1, 1)); // lw x16,(x20)
    va.push_back(mk(1, 16, 16, 1, 1, 17, 1, 0, 0, 1,  0, 0, 0,  2, 0, 1, 1)); // frozen
    va.push_back(mk(1, 16, 16, 1, 1, 17, 1, 0, 0, 1,  0, 0, 0,  2, 0, 1, 1)); // frozen
    va.push_back(mk(1, 16, 16, 1, 1, 17, 1, 0, 1, 1,  0, 0, 0,  2, 0, 1, 1)); // frozen, redirect
    va.push_back(mk(1, 16, 16, 1, 1, 17, 1, 0, 0, 0,  1, 0, 1,  0, 0, 2, 1)); // thaw: stall
    va.push_back(mk(1, 16, 16, 1, 1, 17, 1, 0, 0, 0,  0, 0, 0,  3, 3, 2, 1)); // resolves
    va.push_back(mk(1,  1,  2, 1, 1, 21, 1, 0, 0, 0,  0, 0, 0,  0, 0, 2, 1)); // add x21
    va.push_back(mk(1, 17, 21, 1, 1, 22, 1, 0, 0, 0,  0, 0, 0,  3, 2, 2, 1)); // k=2 and k=1
    va.push_back(mk(1, 17,  0, 1, 0, 23, 1, 0, 0, 0,  0, 0, 0,  0, 0, 2, 1)); // x17 in WB stage
    va.push_back(mk(1,  1,  0, 1, 0, 30, 1, 1, 0, 0,  0, 0, 0,  0, 0, 2, 1)); // lw x30

    vb.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0)); // lw x7
    vb.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  1, 0, 1,  0, 0, 1, 0)); // stall 1
    vb.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  1, 0, 1,  0, 0, 2, 0)); // stall 2
    vb.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  0, 0, 0,  4, 4, 2, 0)); // select 4
    vb.push_back(mk(1,  1,  0, 1, 0,  9, 1, 1, 0, 0,  0, 0, 0,  0, 0, 2, 0)); // lw x9
    vb.push_back(mk(1,  9,  9, 1, 1, 10, 1, 0, 0, 0,  1, 0, 1,  0, 0, 3, 0)); // cnt -> 3
    vb.push_back(mk(1,  9,  9, 1, 1, 10, 1, 0, 0, 0,  1, 0, 1,  0, 0, 3, 0)); // saturated
    vb.push_back(mk(1,  9,  9, 1, 1, 10, 1, 0, 0, 0,  0, 0, 0,  4, 4, 3, 0)); // select 4
    vb.push_back(mk(1,  8,  9, 1, 1, 11, 1, 0, 0, 0,  0, 0, 0,  0, 5, 3, 0)); // WB miss, k=4

    idle_inputs();
    rst_a = 1; rst_b = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 0; rst_b = 0;
    chk("reset a sel_rs1", int'(a_sel1), 0);
    chk("reset a sel_rs2", int'(a_sel2), 0);
    chk("reset a stall_cnt", int'(a_scnt), 0);
    chk("reset a flush_cnt", int'(a_fcnt), 0);
    chk("reset b sel_rs1", int'(b_sel1), 0);
    chk("reset b stall_cnt", int'(b_scnt), 0);

    foreach (va[i]) run_vec(va[i], 1'b0, $sformatf("a[%0d]", i));

    // Reset while frozen and redirecting still clears the pending load x30.
    @(negedge clk);
    rst_a = 1; freeze = 1; redirect = 1;
    @(posedge clk);
    #1;
    rst_a = 0;
    chk("midrst sel_rs1", int'(a_sel1), 0);
    chk("midrst stall_cnt", int'(a_scnt), 0);
    chk("midrst flush_cnt", int'(a_fcnt), 0);
    run_vec(mk(1, 30, 30, 1, 1, 31, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0), 1'b0, "after midrst");

    @(negedge clk);
    idle_inputs();
    rst_b = 1;
    @(posedge clk);
    #1;
    rst_b = 0;
    foreach (vb[i]) run_vec(vb[i], 1'b1, $sformatf("b[%0d]", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It generalises the fixed single-source write-back bypass to a DEPTH-stage back end. It keeps a shadow pipeline of in-flight destination registers and decides per cycle whether to forward, stall the decode stage for a load-use hazard, flush on redirect, or freeze on an external stall. It sits beside the decoder. Its registered forward selects drive the EX operand muxes, and its stall/flush outputs drive the PC register and the IF/ID stage register.

## Interface
- DEPTH, 3, number of stages after decode (stage 1 = EX, stage DEPTH = write-back); legal 2..6
- ALU_RDY, 2, first stage whose source register holds a non-load result; 2 ≤ ALU_RDY ≤ LOAD_RDY
- LOAD_RDY, 3, first stage whose source register holds load data; LOAD_RDY ≤ DEPTH
- SELW, $clog2(DEPTH+1), width of forward-select codes
- CNTW, 32, width of performance counters

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  5 each  source register addresses
- id_rs1_used, id_rs2_used  in  1 each  source is actually read
- id_rd  in  5  destination register
- id_we  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load
- redirect  in  1  taken branch/JAL/JALR resolved in EX this cycle
- freeze  in  1  external stall (memory not ready); whole pipeline holds
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- flush_id  out  1  kill the IF/ID contents (combinational, equals redirect & ~freeze)
- ex_bubble  out  1  insert NOP into EX at this edge (combinational)
- ex_fwd_sel_rs1, ex_fwd_sel_rs2  out  SELW each  registered selects for the instruction in EX; 0 = register-file value, s = source register of stage s (ALU_RDY..DEPTH)
- stall_cnt, flush_cnt  out  CNTW each  saturating event counters

## Operation
- Shadow entries e[1..DEPTH], each {v, rd, we, ld}. Stage DEPTH writes the register file. The register file is write-through, so e[DEPTH] is never a forwarding source for decode.
- Match: e[k] matches source rsN when all of the following hold: e[k].v, e[k].we, e[k].rd == rsN, rsN != 0, id_rsN_used, id_valid, and 1 ≤ k ≤ DEPTH-1. The youngest match (smallest k) wins.
- Readiness: RDY = ld ? LOAD_RDY : ALU_RDY.
  - If the winning match has k+1 ≥ RDY, the next select is k+1.
  - Otherwise the source is not ready and the hazard flag is raised.
  - With no match, the next select is 0.
- stall_id = hazard & ~redirect & ~freeze. ex_bubble = (hazard | redirect | ~id_valid) & ~freeze.
- Advance on each edge when freeze = 0:
  - e[k+1] ← e[k] for k = 1..DEPTH-1.
  - e[1] ← ex_bubble ? invalid : {1, id_rd, id_we, id_is_load}.
  - ex_fwd_sel_* ← ex_bubble ? 0 : computed selects.
- When freeze = 1, all state and registered outputs hold, and redirect is ignored. Upstream holds redirect until freeze clears.
- Redirect has priority over hazard. The branch in e[1] still advances, and the decode instruction is discarded rather than stalled.
- Counters:
  - stall_cnt increments on cycles with stall_id = 1.
  - flush_cnt increments on cycles with flush_id = 1.
  - Both saturate at all-ones.

## Timing
- Reset: all e[k].v = 0, ex_fwd_sel_* = 0, stall_cnt = flush_cnt = 0. On the first cycle after reset, stall_id = 0 and flush_id = 0 (given redirect = 0).
- Forward-select latency: one cycle. Selects are computed from decode inputs at cycle t and valid while that instruction is in EX at t+1.
- Load-use hazard with defaults (load in EX, dependent instruction in decode): exactly 1 stall cycle, then ex_fwd_sel = 3.
- ALU-to-ALU back-to-back dependence: 0 stalls, ex_fwd_sel = 2.
- A general stall lasts until k+1 ≥ RDY. The count is (RDY-1-k) cycles, re-evaluated each cycle as the producer advances.
- rst asserted mid-operation: the next edge clears everything regardless of freeze or redirect.
- Simultaneous redirect and hazard: flush_id = 1, stall_id = 0, ex_bubble = 1.

## Test plan
- Reset, then `add x5,x1,x2` followed by `sub x6,x5,x3` → stall_id never asserts; ex_fwd_sel_rs1 = 2 while sub is in EX; rs2 select = 0.
- `lw x7,0(x1)` followed by `add x8,x7,x7` → stall_id = 1 for exactly one cycle and ex_bubble = 1 on that cycle; then ex_fwd_sel_rs1 = ex_fwd_sel_rs2 = 3; stall_cnt = 1.
- Two producers of x9 (ALU at stage 2, ALU at stage 1), then a consumer of x9 → youngest wins, select = 2. Also check that rd = x0 producers and id_rs2_used = 0 never cause forwarding or stalls.
- Load-use hazard with redirect asserted in the same cycle → stall_id = 0, flush_id = 1, e[1] becomes a bubble, flush_cnt = 1, stall_cnt unchanged.
- freeze held high for 3 cycles during a pending load-use hazard → all selects and entries hold; stall_cnt does not increment; the stall resolves exactly as in the unfrozen case after freeze drops.
- Parameter variant DEPTH = 5, LOAD_RDY = 4 with a load immediately followed by a dependent instruction → 2 stall cycles, then select = 4. Force stall_cnt to near all-ones and check it saturates at all-ones.
